// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle logic/arithmetic ops and iterative
// multi-cycle MUL/DIV/REM (radix-2, one bit per cycle). One operation in flight.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready operand handshake; a, b, alu_control sampled on accept
//   out_valid/out_ready result handshake; result, zero, illegal held while valid
//
// Optional feature: define ALU_SHIFT_EN to add SLL (0011), SRL (0100) and SRA (0101).
// Without it those opcodes report illegal.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;
    localparam logic [3:0] OP_REM = 4'b1010;
`ifdef ALU_SHIFT_EN
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam int unsigned SW = $clog2(WIDTH);
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]       op_q;
    // acc: product (MUL) or partial remainder (DIV/REM)
    // aux: shifting multiplier (MUL) or dividend/quotient (DIV/REM)
    logic [WIDTH-1:0] acc, aux;
    logic [CW-1:0]    cnt;

    logic             is_multi;
    logic             finish;
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_diff;
    logic [WIDTH-1:0] single_res;
    logic             single_ill;
    logic [WIDTH-1:0] final_res;
    logic             final_ill;

    assign is_multi  = (alu_control == OP_MUL) || (alu_control == OP_DIV) || (alu_control == OP_REM);
    assign finish    = (state == BUSY) && (cnt == '0);
    // Restoring-division step: bring down the next dividend bit and trial-subtract.
    // A zero divisor always subtracts, giving all-ones quotient and remainder = a.
    assign rem_shift = {acc, aux[WIDTH-1]};
    assign rem_ge    = rem_shift >= {1'b0, b_q};
    assign rem_diff  = rem_shift[WIDTH-1:0] - b_q;

`ifdef ALU_SHIFT_EN
    logic [SW-1:0] shamt;
    assign shamt = b_q[SW-1:0];
`endif

    // Single-cycle ops, evaluated from the latched operands
    always_comb begin
        single_res = '0;
        single_ill = 1'b0;
        case (op_q)
            OP_AND: single_res = a_q & b_q;
            OP_OR:  single_res = a_q | b_q;
            OP_ADD: single_res = a_q + b_q;
            OP_SUB: single_res = a_q - b_q;
            OP_SLT: single_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OP_NOR: single_res = ~(a_q | b_q);
`ifdef ALU_SHIFT_EN
            OP_SLL: single_res = a_q << shamt;
            OP_SRL: single_res = a_q >> shamt;
            OP_SRA: single_res = WIDTH'($unsigned($signed(a_q) >>> shamt));
`endif
            default: single_ill = 1'b1;
        endcase
    end

    // Select the value committed when the op finishes
    always_comb begin
        final_res = single_res;
        final_ill = single_ill;
        case (op_q)
            OP_MUL: begin final_res = acc; final_ill = 1'b0; end
            OP_DIV: begin final_res = aux; final_ill = 1'b0; end
            OP_REM: begin final_res = acc; final_ill = 1'b0; end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state; single-cycle ops pass through BUSY with a zero count
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = BUSY;
            BUSY:    if (cnt == '0) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            acc       <= '0;
            aux       <= '0;
            cnt       <= '0;
        end else begin
            in_ready  <= (state_nx == IDLE);
            out_valid <= (state_nx == DONE);
            case (state)
                IDLE: if (in_valid) begin
                    a_q  <= a;
                    b_q  <= b;
                    op_q <= alu_control;
                    acc  <= '0;
                    aux  <= (alu_control == OP_MUL) ? b : a;
                    cnt  <= is_multi ? CW'(WIDTH) : '0;
                end
                BUSY: if (!finish) begin
                    cnt <= cnt - CW'(1);
                    if (op_q == OP_MUL) begin
                        // Shift-add: add the shifted multiplicand for each set multiplier bit
                        if (aux[0]) acc <= acc + a_q;
                        a_q <= a_q << 1;
                        aux <= aux >> 1;
                    end else if (rem_ge) begin
                        acc <= rem_diff;
                        aux <= {aux[WIDTH-2:0], 1'b1};
                    end else begin
                        acc <= rem_shift[WIDTH-1:0];
                        aux <= {aux[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    result  <= final_res;
                    zero    <= (final_res == '0);
                    illegal <= final_ill;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [3:0]  alu_control = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_control(alu_control),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        ill;
        int          lat;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    // Issue one op, measure latency, check outputs, optionally hold backpressure, then release
    task automatic run_op(input vec_t v, input int hold);
        int   n;
        logic busy_ok;
        logic seen;
        @(negedge clk);
        chk({v.name, " in_ready before accept"}, 32'(in_ready), 32'd1);
        in_valid    = 1'b1;
        a           = v.a;
        b           = v.b;
        alu_control = v.op;
        @(posedge clk);
        #1;
        // Garbage on the inputs after accept must not disturb the op
        in_valid    = 1'b0;
        a           = $urandom;
        b           = $urandom;
        alu_control = 4'b0010;
        n = 0; busy_ok = 1'b1; seen = 1'b0;
        while (!seen && n < 200) begin
            if (out_valid) seen = 1'b1;
            else begin
                if (in_ready !== 1'b0) busy_ok = 1'b0;
                @(posedge clk);
                #1;
                n++;
            end
        end
        chk({v.name, " out_valid seen"}, 32'(seen), 32'd1);
        chk({v.name, " latency"}, 32'(n), 32'(v.lat));
        chk({v.name, " in_ready low while busy"}, 32'(busy_ok), 32'd1);
        chk({v.name, " result"}, result, v.res);
        chk({v.name, " zero"}, 32'(zero), 32'(v.z));
        chk({v.name, " illegal"}, 32'(illegal), 32'(v.ill));
        chk({v.name, " in_ready in done"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({v.name, " hold out_valid"}, 32'(out_valid), 32'd1);
            chk({v.name, " hold result"}, result, v.res);
            chk({v.name, " hold in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({v.name, " release in_ready"}, 32'(in_ready), 32'd1);
        chk({v.name, " release out_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic stale;
        vec_t v;

        vecs[0]  = '{"add wrap zero", 4'b0010, 32'h0000_0002, 32'hFFFF_FFFE, 32'h0000_0000, 1'b1, 1'b0, 1};
        vecs[1]  = '{"slt neg<pos",   4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1};
        vecs[2]  = '{"slt pos<neg",   4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1};
        vecs[3]  = '{"and",           4'b0000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, 1'b0, 1};
        vecs[4]  = '{"or",            4'b0001, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 1'b0, 1'b0, 1};
        vecs[5]  = '{"sub wrap",      4'b0110, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1};
        vecs[6]  = '{"nor",           4'b1100, 32'h0F0F_0000, 32'h00F0_0000, 32'hF000_FFFF, 1'b0, 1'b0, 1};
        vecs[7]  = '{"sub equal",     4'b0110, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1, 1'b0, 1};
        vecs[8]  = '{"mul",           4'b1000, 32'h0001_0003, 32'h0002_0001, 32'h0007_0003, 1'b0, 1'b0, 33};
        vecs[9]  = '{"div 100/7",     4'b1001, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0, 33};
        vecs[10] = '{"rem 100/7",     4'b1010, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0, 33};
        vecs[11] = '{"div by zero",   4'b1001, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0, 33};
        vecs[12] = '{"rem by zero",   4'b1010, 32'd5,         32'd0,         32'd5,         1'b0, 1'b0, 33};
`ifdef ALU_SHIFT_EN
        vecs[13] = '{"sra",           4'b0101, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 1'b0, 1};
`else
        vecs[13] = '{"op 0101",       4'b0101, 32'h8000_0000, 32'd4,         32'h0000_0000, 1'b1, 1'b1, 1};
`endif
        vecs[14] = '{"op 1111",       4'b1111, 32'h1234_5678, 32'h1,         32'h0000_0000, 1'b1, 1'b1, 1};
        vecs[15] = '{"mul ones",      4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33};
        vecs[16] = '{"add max+1",     4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset zero", 32'(zero), 32'd0);
        chk("reset illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) run_op(vecs[i], 0);

        // Backpressure on a completed DIV
        v = '{"div backpressure", 4'b1001, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33};
        run_op(v, 5);

        // Reset in the middle of a DIV
        @(negedge clk);
        in_valid = 1'b1; a = 32'd1000; b = 32'd3; alu_control = 4'b1001;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid-div in_ready", 32'(in_ready), 32'd0);
        chk("mid-div out_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        #1;
        chk("abort in_ready", 32'(in_ready), 32'd1);
        chk("abort out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        stale = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) stale = 1'b1;
        end
        chk("no stale output after abort", 32'(stale), 32'd0);
        v = '{"add after abort", 4'b0010, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1};
        run_op(v, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
